// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit / request-to-send, shifts
// the frame on device clock falls, checks the device ACK with a timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned TIMER_W = 20;
  localparam int unsigned BCNT_W  = 4;
  localparam int unsigned SR_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_RTS, ST_SEND, ST_ACK, ST_WAIT_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic done_evt, err_evt;
  logic fall_c, timeout_c, inhibit_end_c;

  // Two-stage synchronizers plus previous-clock flop for edge detection
  always_comb begin
    clk_s1_d   = ps2_clk_in;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_dat_in;
    dat_s2_d   = dat_s1_q;
  end

  assign fall_c        = clk_prev_q & ~clk_s2_q;
  assign timeout_c     = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign inhibit_end_c = (timer_q == TIMER_W'(INHIBIT_CYCLES - 1));

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      bcnt_q     <= '0;
      timer_q    <= '0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      timer_q    <= timer_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next state and frame datapath
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bcnt_d   = bcnt_q;
    timer_d  = timer_q;
    done_evt = 1'b0;
    err_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          sr_d    = {1'b1, ~^tx_data, tx_data};
          bcnt_d  = '0;
          timer_d = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (inhibit_end_c) state_d = ST_RTS;
      end
      ST_RTS: begin
        timer_d = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (fall_c) begin
          sr_d    = {1'b0, sr_q[SR_W-1:1]};
          bcnt_d  = bcnt_q + BCNT_W'(1);
          timer_d = '0;
          if (bcnt_q == BCNT_W'(9)) state_d = ST_ACK;
        end else if (timeout_c) begin
          err_evt = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_ACK: begin
        if (fall_c) begin
          timer_d = '0;
          if (dat_s2_q) begin
            err_evt = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end else if (timeout_c) begin
          err_evt = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          done_evt = 1'b1;
          state_d  = ST_IDLE;
        end else if (fall_c) begin
          timer_d = '0;
        end else if (timeout_c) begin
          err_evt = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state; data bit is shifted out on each fall
  always_comb begin
    clk_oe_d = 1'b0;
    dat_oe_d = 1'b0;
    ready_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = done_evt;
    error_d  = err_evt;
    case (state_d)
      ST_INHIBIT: clk_oe_d = 1'b1;
      ST_RTS: begin
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b1;
      end
      ST_SEND: dat_oe_d = (state_q == ST_SEND && fall_c) ? ~sr_q[0] : dat_oe_q;
      default: ;
    endcase
  end

  assign tx_ready   = ready_q;
  assign busy       = busy_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It implements the bus-inhibit / request-to-send sequence, shifts the frame on device-generated clock edges, and checks the device acknowledge. It sits beside the PS/2 scan-code receiver on the same PS2_CLK/PS2_DAT pins. While busy is high the receiver's input is to be ignored.

## Interface
Parameters:
- INHIBIT_CYCLES, default 5000: clock-low inhibit time in board_clk cycles (100 us at 50 MHz).
- TIMEOUT_CYCLES, default 750000: maximum wait for any expected device clock edge (15 ms).

Ports:
- board_clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid & tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (pull-up).
- ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: frame acknowledged.
- tx_error  out  1  one-cycle pulse: timeout or missing ACK.

## Operation
- Input conditioning: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer. A falling edge (fall) is a registered synchronized clock of 1 followed by a current value of 0.
- Frame registers, loaded on accept:
  - Shift register sr[9:0] = {1'b1 stop, odd parity, tx_data}, where parity = ~^tx_data.
  - Bit counter bcnt, 4 bits.
  - Timer, 20 bits.
- IDLE:
  - Both oe = 0, tx_ready = 1.
  - On accept: load sr, bcnt = 0, timer = 0, go to INHIBIT.
- INHIBIT:
  - ps2_clk_oe = 1; timer counts up.
  - When timer == INHIBIT_CYCLES-1: go to RTS.
- RTS (one cycle):
  - ps2_clk_oe = 1, ps2_dat_oe = 1 (start bit 0).
  - Go to SEND with timer = 0.
- SEND:
  - ps2_clk_oe = 0; ps2_dat_oe = ~sr[0].
  - On each fall: sr shifts right, bcnt increments, timer clears.
  - The fall that makes bcnt == 10 releases data (stop bit) and enters ACK.
- ACK:
  - Both oe = 0.
  - On fall, sample synchronized data: 0 → WAIT_IDLE; 1 → pulse tx_error, go to IDLE.
- WAIT_IDLE:
  - When synchronized clock and data are both 1: pulse tx_done, go to IDLE.
- Timeout:
  - In SEND, ACK and WAIT_IDLE, timer counts each cycle with no fall.
  - When timer == TIMEOUT_CYCLES-1: both oe = 0, pulse tx_error, go to IDLE.
- tx_valid while not in IDLE is ignored; no queueing.
- tx_data is sampled only on the accept cycle.

## Timing
- Reset values, applied asynchronously and immediately:
  - State IDLE.
  - ps2_clk_oe = 0, ps2_dat_oe = 0.
  - tx_ready = 1, busy = 0, tx_done = 0, tx_error = 0.
  - sr, bcnt and timer = 0.
- Reset mid-frame releases both lines on the same edge it asserts. No done or error pulse is produced.
- Accept on edge N:
  - ps2_clk_oe = 1 from N+1 through N+INHIBIT_CYCLES.
  - RTS at N+INHIBIT_CYCLES+1.
  - ps2_clk_oe falls to 0 at N+INHIBIT_CYCLES+2; ps2_dat_oe stays 1.
- Fall detection latency is 3 board_clk cycles after the pin edge. ps2_dat_oe updates on the cycle after detection, well inside the device clock-low phase (≥30 us).
- Falls in SEND: #1 puts d0 ... #8 puts d7; #9 puts parity; #10 releases (stop).
- Fall #11 (in ACK) samples ACK.
- All outputs are registered. tx_done and tx_error are mutually exclusive and last exactly one cycle. busy = ~tx_ready.
- A fall arriving in the same cycle as the timeout terminal count counts as a fall; the timeout does not fire.

## Test plan
- 0xED, device model acknowledges: parity bit = 1. Line-level bits at falls 1–10 are 1,0,1,1,0,1,1,1,1,(released). tx_done pulses once; busy drops the same cycle.
- 0x01: parity 0, so dat_oe = 1 during the parity bit. 0x00: parity 1. Check each with bit-accurate compare.
- Inhibit length: with INHIBIT_CYCLES = 50, ps2_clk_oe is high exactly 51 cycles counting the RTS cycle. ps2_dat_oe rises at cycle 51 after accept.
- Device never clocks (TIMEOUT_CYCLES = 1000): tx_error at accept+INHIBIT+2+1000 ± 1, both oe = 0, tx_ready = 1.
- Device leaves data high at fall 11: tx_error pulses, no tx_done. A new 0xF4 request is accepted the next cycle.
- Reset asserted after fall 5: oe outputs = 0 immediately and state is IDLE. tx_valid held high during SEND creates no second frame.
